ball_handoff_scheduler: RTL and testbench
=========================================

BALL_HANDOFF_SCHEDULER -- requirements
Module: ball_handoff_scheduler

Interface
REQ-001 SHALL have parameter TIMEOUT_CYC, default 25000: cycles to wait for i2c_done before an attempt counts as failed.
REQ-002 SHALL have parameter MAX_RETRY, default 3: maximum re-attempts after the first attempt (used only when HANDOFF_RETRY_EN is defined).
REQ-003 SHALL have parameter BACKOFF_CYC, default 256: idle cycles between a failed attempt and its retry.
REQ-004 SHALL have port clk, input, 1: single system clock.
REQ-005 SHALL have port reset, input, 1: synchronous, active-low reset.
REQ-006 SHALL have port game_start, input, 1: debounced pulse that arms the scheduler.
REQ-007 SHALL have port ball_exit, input, 1: one-cycle pulse when the ball leaves the local screen edge.
REQ-008 SHALL have port ball_y, input, 10: ball Y position at exit.
REQ-009 SHALL have ports ball_vy, gravity and ball_speed, input, 8 each: ball vertical speed, gravity counter and horizontal speed at exit.
REQ-010 SHALL have port win_flag, input, 1: the local player has lost the rally or the game.
REQ-011 SHALL have port i2c_done, input, 1: one-cycle completion pulse from the I2C master.
REQ-012 SHALL have port i2c_ack_err, input, 1: NACK indication, qualified by i2c_done.
REQ-013 SHALL have ports slv_reg0_y0 to slv_reg5_win_flag, output, 8 each: the transfer register image.
REQ-014 SHALL have port i2c_start, output, 1: one-cycle pulse that starts a transfer.
REQ-015 SHALL have ports busy, handoff_ok and handoff_fail, output, 1 each: busy is a level; handoff_ok and handoff_fail are one-cycle pulses.
REQ-016 SHALL have port state_dbg, output, 3: encoding of the current FSM state.

Function
REQ-017 SHALL implement the states IDLE=0, ARMED=1, LOAD=2, START=3, WAIT=4, BACKOFF=5 and DONE=6.
REQ-018 IDLE -> ARMED on game_start; all other inputs are ignored in IDLE.
REQ-019 ARMED -> LOAD on ball_exit; LOAD captures the transfer image and goes to START in the next cycle.
REQ-020 LOAD SHALL capture the image as follows:
- reg0 = ball_y[7:0]
- reg1 = {6'b0, ball_y[9:8]}
- reg2 = ball_vy
- reg3 = gravity
- reg4 = ball_speed
- reg5 = {7'b0, win_flag}
REQ-021 The capture is taken from input values in the cycle ball_exit is high (one-cycle input register); the image stays stable until the next LOAD.
REQ-022 START SHALL assert i2c_start for exactly one cycle, clear the timeout counter, and go to WAIT.
REQ-023 WAIT SHALL handle completion and timeout as follows:
- i2c_done with i2c_ack_err=0 -> DONE.
- i2c_done with i2c_ack_err=1 -> failed attempt.
- Timeout counter reaching TIMEOUT_CYC-1 without i2c_done -> failed attempt.
- i2c_done in the same cycle as the timeout: i2c_done has priority.
REQ-024 DONE SHALL pulse handoff_ok for one cycle, then go to ARMED; if reg5[0]=1, it goes to IDLE instead (game over).
REQ-025 busy SHALL be 1 in LOAD, START, WAIT and BACKOFF, and 0 otherwise.
REQ-026 A ball_exit arriving while busy SHALL be dropped and SHALL NOT alter the captured image.
REQ-027 A game_start arriving while not in IDLE SHALL reset the retry count and return the FSM to ARMED without pulsing i2c_start.
REQ-028 Counters SHALL saturate and never wrap:
- timeout counter: ceil(log2(TIMEOUT_CYC)) bits
- retry counter: ceil(log2(MAX_RETRY+1)) bits

Reset
REQ-029 When reset=0 at a clk edge, the FSM SHALL go to IDLE, all counters SHALL clear, and slv_reg0..5 SHALL be 0x00.
REQ-030 When reset=0 at a clk edge, i2c_start, busy, handoff_ok and handoff_fail SHALL be 0, and state_dbg SHALL be 0.
REQ-031 A reset asserted mid-WAIT SHALL abort the transfer with no handoff_fail pulse; a later i2c_done SHALL be ignored in IDLE.

Configuration
REQ-032 With macro HANDOFF_RETRY_EN defined, a failed attempt SHALL be handled as follows:
- If the retry count is below MAX_RETRY: increment the count, go to BACKOFF, wait BACKOFF_CYC cycles, then go to START.
- If the retry count equals MAX_RETRY: pulse handoff_fail and go to ARMED.
- In both cases the image is not recaptured.
REQ-033 With HANDOFF_RETRY_EN undefined, the retry counter and BACKOFF logic SHALL be absent; a failed attempt SHALL pulse handoff_fail and go to ARMED.

Verification
REQ-034 Scenario: game_start, then ball_exit with ball_y=0x2A5, vy=0x05, gravity=0x02, speed=0x03, win_flag=0 -> regs 0xA5, 0x02, 0x05, 0x02, 0x03, 0x00; i2c_start one cycle, 2 cycles after ball_exit; i2c_done(err=0) -> handoff_ok one cycle; state ARMED.
REQ-035 Scenario: i2c_done never arrives -> failed attempt exactly TIMEOUT_CYC cycles after i2c_start.
- With the macro: 4 i2c_start pulses spaced TIMEOUT_CYC+BACKOFF_CYC+1 apart, then handoff_fail.
- Without the macro: handoff_fail after the first attempt.
REQ-036 Scenario (macro defined): i2c_done with err=1 twice, then err=0 -> 3 i2c_start pulses, handoff_ok, no handoff_fail, regs unchanged across retries.
REQ-037 Scenario: second ball_exit with ball_y=0x011 during WAIT -> reg0 stays 0xA5; i2c_done in the same cycle as the timeout -> handoff_ok.
REQ-038 Scenario: reset=0 for one cycle during WAIT -> all outputs 0 and state_dbg=0; a following i2c_done -> no handoff_ok.
REQ-039 Scenario: win_flag=1 transfer completes -> reg5=0x01, handoff_ok, state IDLE; a following ball_exit -> no i2c_start.

Source files
------------

// File: rtl/ball_handoff_scheduler.sv
// ball_handoff_scheduler: captures the ball state on screen exit, launches an I2C
// register transfer to the neighbouring screen, and reports success or failure.
// Optional feature macro HANDOFF_RETRY_EN adds bounded retries with a backoff gap.
module ball_handoff_scheduler #(
   parameter int unsigned TIMEOUT_CYC = 25000,
   parameter int unsigned MAX_RETRY   = 3,
   parameter int unsigned BACKOFF_CYC = 256
) (
   input  logic       clk,
   input  logic       reset,
   input  logic       game_start,
   input  logic       ball_exit,
   input  logic [9:0] ball_y,
   input  logic [7:0] ball_vy,
   input  logic [7:0] gravity,
   input  logic [7:0] ball_speed,
   input  logic       win_flag,
   input  logic       i2c_done,
   input  logic       i2c_ack_err,
   output logic [7:0] slv_reg0_y0,
   output logic [7:0] slv_reg1_y1,
   output logic [7:0] slv_reg2_vy,
   output logic [7:0] slv_reg3_gravity,
   output logic [7:0] slv_reg4_speed,
   output logic [7:0] slv_reg5_win_flag,
   output logic       i2c_start,
   output logic       busy,
   output logic       handoff_ok,
   output logic       handoff_fail,
   output logic [2:0] state_dbg
);

   localparam logic [2:0] S_IDLE    = 3'd0;
   localparam logic [2:0] S_ARMED   = 3'd1;
   localparam logic [2:0] S_LOAD    = 3'd2;
   localparam logic [2:0] S_START   = 3'd3;
   localparam logic [2:0] S_WAIT    = 3'd4;
   localparam logic [2:0] S_BACKOFF = 3'd5;
   localparam logic [2:0] S_DONE    = 3'd6;

   localparam int unsigned TO_W = (TIMEOUT_CYC > 1) ? $clog2(TIMEOUT_CYC) : 1;
   localparam logic [TO_W-1:0] TO_LAST = TO_W'(TIMEOUT_CYC - 1);
   localparam logic [TO_W-1:0] TO_SAT  = '1;

   // Reject configurations the timing scheme cannot honour.
   if (TIMEOUT_CYC < 2 || BACKOFF_CYC < 1 || MAX_RETRY > 255) begin : g_bad_cfg
      $error("ball_handoff_scheduler: unsupported TIMEOUT_CYC/BACKOFF_CYC/MAX_RETRY");
   end

   logic [2:0]      state, state_nxt;
   logic [TO_W-1:0] to_cnt, to_cnt_nxt;
   logic            attempt_fail_c;
   logic            give_up_c;

   // Ball state latched in the cycle the exit pulse is accepted.
   logic [9:0] cap_y;
   logic [7:0] cap_vy, cap_grav, cap_speed;
   logic       cap_win;

`ifdef HANDOFF_RETRY_EN
   localparam int unsigned RT_W = (MAX_RETRY > 0) ? $clog2(MAX_RETRY + 1) : 1;
   localparam logic [RT_W-1:0] RT_MAX = RT_W'(MAX_RETRY);
   localparam int unsigned BO_W = (BACKOFF_CYC > 1) ? $clog2(BACKOFF_CYC) : 1;
   localparam logic [BO_W-1:0] BO_LAST = BO_W'(BACKOFF_CYC - 1);

   logic [RT_W-1:0] rt_cnt, rt_cnt_nxt;
   logic [BO_W-1:0] bo_cnt, bo_cnt_nxt;
`endif

   assign state_dbg = state;

   // Next-state, counter and event decode.
   always_comb begin
      state_nxt      = state;
      to_cnt_nxt     = to_cnt;
      attempt_fail_c = 1'b0;
      give_up_c      = 1'b0;
`ifdef HANDOFF_RETRY_EN
      rt_cnt_nxt     = rt_cnt;
      bo_cnt_nxt     = bo_cnt;
`endif
      case (state)
         S_IDLE:  if (game_start) state_nxt = S_ARMED;
         S_ARMED: if (ball_exit) state_nxt = S_LOAD;
         S_LOAD: begin
            state_nxt = S_START;
`ifdef HANDOFF_RETRY_EN
            rt_cnt_nxt = '0;
`endif
         end
         S_START: begin
            to_cnt_nxt = '0;
            state_nxt  = S_WAIT;
         end
         S_WAIT: begin
            if (i2c_done) begin
               if (i2c_ack_err) attempt_fail_c = 1'b1;
               else             state_nxt = S_DONE;
            end else if (to_cnt == TO_LAST) begin
               attempt_fail_c = 1'b1;
            end else if (to_cnt != TO_SAT) begin
               to_cnt_nxt = to_cnt + 1'b1;
            end
         end
         S_BACKOFF: begin
`ifdef HANDOFF_RETRY_EN
            if (bo_cnt == BO_LAST) state_nxt = S_START;
            else                   bo_cnt_nxt = bo_cnt + 1'b1;
`else
            state_nxt = S_ARMED;
`endif
         end
         S_DONE:  state_nxt = slv_reg5_win_flag[0] ? S_IDLE : S_ARMED;
         default: state_nxt = S_IDLE;
      endcase

      // A failed attempt either schedules a retry or gives up.
      if (attempt_fail_c) begin
`ifdef HANDOFF_RETRY_EN
         if (rt_cnt < RT_MAX) begin
            rt_cnt_nxt = rt_cnt + 1'b1;
            bo_cnt_nxt = '0;
            state_nxt  = S_BACKOFF;
         end else begin
            give_up_c = 1'b1;
            state_nxt = S_ARMED;
         end
`else
         give_up_c = 1'b1;
         state_nxt = S_ARMED;
`endif
      end

      // Re-arm request outside IDLE overrides everything, silently.
      if (game_start && state != S_IDLE) begin
         state_nxt = S_ARMED;
         give_up_c = 1'b0;
`ifdef HANDOFF_RETRY_EN
         rt_cnt_nxt = '0;
`endif
      end
   end

   // State, capture, register image and registered status outputs.
   always_ff @(posedge clk) begin
      if (!reset) begin
         state             <= S_IDLE;
         to_cnt            <= '0;
         cap_y             <= '0;
         cap_vy            <= '0;
         cap_grav          <= '0;
         cap_speed         <= '0;
         cap_win           <= 1'b0;
         slv_reg0_y0       <= '0;
         slv_reg1_y1       <= '0;
         slv_reg2_vy       <= '0;
         slv_reg3_gravity  <= '0;
         slv_reg4_speed    <= '0;
         slv_reg5_win_flag <= '0;
         i2c_start         <= 1'b0;
         busy              <= 1'b0;
         handoff_ok        <= 1'b0;
         handoff_fail      <= 1'b0;
      end else begin
         state  <= state_nxt;
         to_cnt <= to_cnt_nxt;
         if (state == S_ARMED && state_nxt == S_LOAD) begin
            cap_y     <= ball_y;
            cap_vy    <= ball_vy;
            cap_grav  <= gravity;
            cap_speed <= ball_speed;
            cap_win   <= win_flag;
         end
         if (state == S_LOAD) begin
            slv_reg0_y0       <= cap_y[7:0];
            slv_reg1_y1       <= {6'b0, cap_y[9:8]};
            slv_reg2_vy       <= cap_vy;
            slv_reg3_gravity  <= cap_grav;
            slv_reg4_speed    <= cap_speed;
            slv_reg5_win_flag <= {7'b0, cap_win};
         end
         i2c_start    <= (state_nxt == S_START);
         busy         <= (state_nxt == S_LOAD) || (state_nxt == S_START) ||
                         (state_nxt == S_WAIT) || (state_nxt == S_BACKOFF);
         handoff_ok   <= (state_nxt == S_DONE);
         handoff_fail <= give_up_c;
      end
   end

`ifdef HANDOFF_RETRY_EN
   // Retry and backoff counters.
   always_ff @(posedge clk) begin
      if (!reset) begin
         rt_cnt <= '0;
         bo_cnt <= '0;
      end else begin
         rt_cnt <= rt_cnt_nxt;
         bo_cnt <= bo_cnt_nxt;
      end
   end
`endif

endmodule

// File: tb/tb_ball_handoff_scheduler.sv
// tb_ball_handoff_scheduler: randomized handoffs checked against an event-time
// model (start/ok/fail cycles derived arithmetically from attempt outcomes).
module tb_ball_handoff_scheduler;

   localparam int unsigned T = 20;
   localparam int unsigned R = 3;
   localparam int unsigned B = 6;
`ifdef HANDOFF_RETRY_EN
   localparam bit RETRY_EN = 1'b1;
`else
   localparam bit RETRY_EN = 1'b0;
`endif

   logic       clk = 1'b0;
   logic       reset = 1'b0;
   logic       game_start = 1'b0;
   logic       ball_exit = 1'b0;
   logic [9:0] ball_y = '0;
   logic [7:0] ball_vy = '0, gravity = '0, ball_speed = '0;
   logic       win_flag = 1'b0;
   logic       i2c_done = 1'b0;
   logic       i2c_ack_err = 1'b0;
   logic [7:0] slv_reg0_y0, slv_reg1_y1, slv_reg2_vy, slv_reg3_gravity;
   logic [7:0] slv_reg4_speed, slv_reg5_win_flag;
   logic       i2c_start, busy, handoff_ok, handoff_fail;
   logic [2:0] state_dbg;

   ball_handoff_scheduler #(.TIMEOUT_CYC(T), .MAX_RETRY(R), .BACKOFF_CYC(B)) dut (
      .clk(clk), .reset(reset), .game_start(game_start), .ball_exit(ball_exit),
      .ball_y(ball_y), .ball_vy(ball_vy), .gravity(gravity), .ball_speed(ball_speed),
      .win_flag(win_flag), .i2c_done(i2c_done), .i2c_ack_err(i2c_ack_err),
      .slv_reg0_y0(slv_reg0_y0), .slv_reg1_y1(slv_reg1_y1), .slv_reg2_vy(slv_reg2_vy),
      .slv_reg3_gravity(slv_reg3_gravity), .slv_reg4_speed(slv_reg4_speed),
      .slv_reg5_win_flag(slv_reg5_win_flag), .i2c_start(i2c_start), .busy(busy),
      .handoff_ok(handoff_ok), .handoff_fail(handoff_fail), .state_dbg(state_dbg)
   );

   always #5 clk = ~clk;

   int n_vec = 0;
   int n_err = 0;
   int pd[0:7];
   bit pe[0:7];

   // Single comparison point: counts and reports.
   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_vec++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got 0x%0h expected 0x%0h at t=%0t", tag, got, exp, $time);
      end
   endtask

   task automatic arm();
      game_start = 1'b1;
      @(negedge clk);
      game_start = 1'b0;
      chk("arm_state", 32'(state_dbg), 32'd1);
   endtask

   // One handoff: pd/pe describe each attempt (pd > T means no response).
   task automatic run_handoff(input logic [9:0] y, input logic [7:0] vy, input logic [7:0] g,
                              input logic [7:0] sp, input bit win, input bit spur,
                              output bit went_idle);
      int st[0:7];
      int dn[0:7];
      bit de[0:7];
      int nst = 0, ndn = 0;
      int ok_t = -1, fail_t = -1, last_rc = 0, s = 2, spur_at = -1, rc;
      logic [7:0] er[0:5];
      er[0] = y[7:0]; er[1] = {6'b0, y[9:8]}; er[2] = vy; er[3] = g; er[4] = sp;
      er[5] = {7'b0, win};
      for (int a = 0; a <= int'(R); a++) begin
         rc = s + ((pd[a] > int'(T)) ? int'(T) : pd[a]);
         st[nst] = s; nst++;
         if (pd[a] <= int'(T)) begin dn[ndn] = rc; de[ndn] = pe[a]; ndn++; end
         last_rc = rc;
         if (pd[a] <= int'(T) && !pe[a]) begin ok_t = rc + 1; break; end
         if (RETRY_EN && a < int'(R)) s = rc + 1 + int'(B);
         else begin fail_t = rc + 1; break; end
      end
      if (spur) spur_at = int'($urandom_range(last_rc, 1));
      for (int c = 0; c <= last_rc + 1; c++) begin
         bit es = 1'b0, ed = 1'b0, ee = 1'b0;
         for (int k = 0; k < nst; k++) if (st[k] == c) es = 1'b1;
         for (int k = 0; k < ndn; k++) if (dn[k] == c) begin ed = 1'b1; ee = de[k]; end
         chk("i2c_start", 32'(i2c_start), 32'(es));
         chk("handoff_ok", 32'(handoff_ok), 32'(c == ok_t));
         chk("handoff_fail", 32'(handoff_fail), 32'(c == fail_t));
         chk("busy", 32'(busy), 32'(c >= 1 && c <= last_rc));
         if (c >= 2) chk("reg0_hold", 32'(slv_reg0_y0), 32'(er[0]));
         if (c == ok_t) chk("state_done", 32'(state_dbg), 32'd6);
         ball_exit   = (c == 0) || (c == spur_at);
         ball_y      = (c == 0) ? y  : (c == spur_at) ? 10'h011 : 10'($urandom);
         ball_vy     = (c == 0) ? vy : 8'($urandom);
         gravity     = (c == 0) ? g  : 8'($urandom);
         ball_speed  = (c == 0) ? sp : 8'($urandom);
         win_flag    = (c == 0) ? win : 1'($urandom);
         i2c_done    = ed;
         i2c_ack_err = ed ? ee : 1'($urandom);
         @(negedge clk);
      end
      ball_exit = 1'b0; i2c_done = 1'b0; i2c_ack_err = 1'b0;
      went_idle = (ok_t >= 0) && win;
      chk("end_state", 32'(state_dbg), went_idle ? 32'd0 : 32'd1);
      chk("reg0", 32'(slv_reg0_y0), 32'(er[0]));
      chk("reg1", 32'(slv_reg1_y1), 32'(er[1]));
      chk("reg2", 32'(slv_reg2_vy), 32'(er[2]));
      chk("reg3", 32'(slv_reg3_gravity), 32'(er[3]));
      chk("reg4", 32'(slv_reg4_speed), 32'(er[4]));
      chk("reg5", 32'(slv_reg5_win_flag), 32'(er[5]));
   endtask

   // Pulse ball_exit with given Y and step until the FSM sits in WAIT.
   task automatic exit_to_wait(input logic [9:0] y);
      ball_exit = 1'b1; ball_y = y;
      @(negedge clk);
      ball_exit = 1'b0;
      repeat (2) @(negedge clk);
      chk("in_wait", 32'(state_dbg), 32'd4);
   endtask

   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      bit idle;
      repeat (2) @(negedge clk);
      chk("rst_state", 32'(state_dbg), 32'd0);
      chk("rst_start", 32'(i2c_start), 32'd0);
      chk("rst_busy", 32'(busy), 32'd0);
      chk("rst_ok", 32'(handoff_ok), 32'd0);
      chk("rst_fail", 32'(handoff_fail), 32'd0);
      chk("rst_reg0", 32'(slv_reg0_y0), 32'd0);
      chk("rst_reg5", 32'(slv_reg5_win_flag), 32'd0);
      reset = 1'b1;

      // IDLE ignores everything but game_start
      ball_exit = 1'b1; i2c_done = 1'b1;
      @(negedge clk);
      ball_exit = 1'b0; i2c_done = 1'b0;
      @(negedge clk);
      chk("idle_ignore", 32'(state_dbg), 32'd0);
      chk("idle_nostart", 32'(i2c_start), 32'd0);
      arm();

      // basic successful handoff
      pd[0] = 5; pe[0] = 1'b0;
      run_handoff(10'h2A5, 8'h05, 8'h02, 8'h03, 1'b0, 1'b0, idle);

      // no response at all: timeout path
      for (int a = 0; a < 8; a++) begin pd[a] = int'(T) + 1; pe[a] = 1'b0; end
      run_handoff(10'($urandom), 8'($urandom), 8'($urandom), 8'($urandom), 1'b0, 1'b0, idle);

      // NACK twice then success
      pd[0] = 3; pe[0] = 1'b1; pd[1] = 7; pe[1] = 1'b1; pd[2] = 4; pe[2] = 1'b0;
      run_handoff(10'h1C3, 8'h11, 8'h22, 8'h33, 1'b0, 1'b0, idle);

      // dropped exit while busy, done coincident with timeout
      pd[0] = int'(T); pe[0] = 1'b0;
      run_handoff(10'h2A5, 8'h05, 8'h02, 8'h03, 1'b0, 1'b1, idle);

      // game_start mid-WAIT re-arms quietly; later done is ignored
      exit_to_wait(10'h0F0);
      game_start = 1'b1;
      @(negedge clk);
      game_start = 1'b0;
      chk("rearm_state", 32'(state_dbg), 32'd1);
      chk("rearm_busy", 32'(busy), 32'd0);
      i2c_done = 1'b1;
      for (int c = 0; c < int'(T) + 4; c++) begin
         chk("rearm_nostart", 32'(i2c_start), 32'd0);
         @(negedge clk);
         i2c_done = 1'b0;
         chk("rearm_nook", 32'(handoff_ok), 32'd0);
         chk("rearm_nofail", 32'(handoff_fail), 32'd0);
      end
      chk("rearm_stay", 32'(state_dbg), 32'd1);

      // reset mid-WAIT aborts without a fail pulse
      exit_to_wait(10'h155);
      reset = 1'b0;
      @(negedge clk);
      reset = 1'b1;
      chk("rw_state", 32'(state_dbg), 32'd0);
      chk("rw_start", 32'(i2c_start), 32'd0);
      chk("rw_busy", 32'(busy), 32'd0);
      chk("rw_ok", 32'(handoff_ok), 32'd0);
      chk("rw_fail", 32'(handoff_fail), 32'd0);
      chk("rw_reg0", 32'(slv_reg0_y0), 32'd0);
      chk("rw_reg1", 32'(slv_reg1_y1), 32'd0);
      i2c_done = 1'b1;
      @(negedge clk);
      i2c_done = 1'b0;
      for (int c = 0; c < 3; c++) begin
         chk("rw_nook", 32'(handoff_ok), 32'd0);
         chk("rw_nofail", 32'(handoff_fail), 32'd0);
         chk("rw_idle", 32'(state_dbg), 32'd0);
         @(negedge clk);
      end
      arm();

      // game-over transfer lands in IDLE, later exits ignored
      pd[0] = 3; pe[0] = 1'b0;
      run_handoff(10'($urandom), 8'($urandom), 8'($urandom), 8'($urandom), 1'b1, 1'b0, idle);
      ball_exit = 1'b1;
      @(negedge clk);
      ball_exit = 1'b0;
      for (int c = 0; c < 4; c++) begin
         chk("go_nostart", 32'(i2c_start), 32'd0);
         chk("go_idle", 32'(state_dbg), 32'd0);
         @(negedge clk);
      end
      arm();

      // randomized handoffs
      repeat (30) begin
         for (int a = 0; a < 8; a++) begin
            pd[a] = ($urandom_range(3) == 0) ? int'(T) + 1 : int'($urandom_range(T, 1));
            pe[a] = ($urandom_range(2) == 0);
         end
         run_handoff(10'($urandom), 8'($urandom), 8'($urandom), 8'($urandom),
                     ($urandom_range(3) == 0), 1'($urandom), idle);
         if (idle) arm();
      end

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
